// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, next-pc, instr} FIFO between fetch and decode, with
// redirect flush and stale-response drop. FETCH_QUEUE_BYPASS_EN enables empty-queue bypass.
module fetch_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_pc_wdata,
    input  logic [31:0]      enq_instr,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_pc_wdata,
    output logic [31:0]      deq_instr,
    input  logic             flush,
    input  logic             resp_outstanding,
    output logic [PTR_W:0]   count
);
    typedef enum logic {RUN, DROP} state_t;

    state_t             state, state_nx;
    logic [95:0]        mem [DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic               byp, wr, rd, nonempty;

    assign nonempty  = (count != '0);
    assign enq_ready = (state == DROP) || (count != (PTR_W+1)'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = !nonempty && (state == RUN) && !flush && enq_valid;
`else
    assign byp = 1'b0;
`endif

    // a bypassed entry that decode takes this cycle never touches storage
    assign wr = enq_valid && enq_ready && (state == RUN) && !flush && !(byp && deq_ready);
    assign rd = nonempty && deq_ready && !flush;

    assign deq_valid = nonempty || byp;
    assign {deq_pc, deq_pc_wdata, deq_instr} = byp ? {enq_pc, enq_pc_wdata, enq_instr} : mem[head];

    always_comb begin
        state_nx = state;
        if (state == RUN)
            state_nx = (flush && resp_outstanding && !enq_valid) ? DROP : RUN;
        else if (flush)
            state_nx = (enq_valid && !resp_outstanding) ? RUN : DROP;
        else
            state_nx = enq_valid ? RUN : DROP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (wr) begin
                    mem[tail] <= {enq_pc, enq_pc_wdata, enq_instr};
                    tail      <= tail + 1'b1;
                end
                if (rd) head <= head + 1'b1;
                count <= count + (PTR_W+1)'(wr) - (PTR_W+1)'(rd);
            end
        end
    end
endmodule
